// File: rtl/prio_enc_pipe.sv
// Priority encoder with one registered output stage and valid/ready flow control.
// Define PRIO_ENC_PIPE_RR_EN for round-robin arbitration; fixed highest-index priority otherwise.
module prio_enc_pipe #(
    parameter int unsigned OUT_SIZE = 4,
    parameter int unsigned IN_SIZE  = 1 << OUT_SIZE
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [IN_SIZE-1:0]  req,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [OUT_SIZE-1:0] out_code,
    output logic [IN_SIZE-1:0]  out_onehot
);

    logic                valid_q, valid_d;
    logic [OUT_SIZE-1:0] code_q, code_d;
    logic [OUT_SIZE-1:0] ptr_q, ptr_d;
    logic [OUT_SIZE-1:0] sel;
    logic                hit;
    logic                load;
    logic                stall;

    always_comb begin : select
        sel = '0;
        hit = |req;
`ifdef PRIO_ENC_PIPE_RR_EN
        begin : rr_search
            logic [OUT_SIZE-1:0] idx;
            logic                found;
            idx   = '0;
            found = 1'b0;
            // Offset IN_SIZE wraps back to ptr itself, so a sole requester at ptr wins again.
            for (int unsigned k = 1; k <= IN_SIZE; k++) begin
                idx = ptr_q + OUT_SIZE'(k);
                if (!found && req[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
`else
        for (int unsigned i = 0; i < IN_SIZE; i++) begin
            if (req[i]) begin
                sel = OUT_SIZE'(i);
            end
        end
`endif
    end

`ifndef PRIO_ENC_PIPE_RR_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_q;
`endif

    assign stall = valid_q && !out_ready;
    assign load  = enable && (!valid_q || out_ready);

    always_comb begin : next_state
        valid_d = valid_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = hit;
            code_d  = hit ? sel : '0;
            if (hit) begin
                ptr_d = sel;
            end
        end else if (!stall) begin
            // Disabled and not stalled: drain the output and go idle.
            valid_d = 1'b0;
            code_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            ptr_q   <= '1;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_code   = code_q;
    assign out_onehot = valid_q ? (IN_SIZE'(1) << code_q) : '0;

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Self-checking bench for prio_enc_pipe: directed literal cases plus randomized traffic
// against a behavioural model. Follows PRIO_ENC_PIPE_RR_EN for the arbitration mode.
module tb_prio_enc_pipe;

    localparam int OW = 4;
    localparam int IN = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [IN-1:0] req;
    logic          out_ready;
    logic          out_valid;
    logic [OW-1:0] out_code;
    logic [IN-1:0] out_onehot;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_valid;
    int m_code;
    int m_ptr;

    prio_enc_pipe #(.OUT_SIZE(OW), .IN_SIZE(IN)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_onehot (out_onehot)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int fixed_pick(input logic [IN-1:0] r);
        for (int i = IN - 1; i >= 0; i--) if (r[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [IN-1:0] r, input int p);
        for (int k = 1; k <= IN; k++) if (r[(p + k) % IN]) return (p + k) % IN;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_code  = 0;
        m_ptr   = IN - 1;
    endtask

    task automatic compare_all(input string tag);
        logic [IN-1:0] exp_oh;
        exp_oh = (m_valid != 0) ? (IN'(1) << m_code) : '0;
        chk({tag, ".no_x"}, 32'($isunknown({out_valid, out_code, out_onehot})), 32'd0);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".code"}, 32'(out_code), 32'(m_code));
        chk({tag, ".onehot"}, 32'(out_onehot), 32'(exp_oh));
    endtask

    // Advance one clock: predict from the inputs present before the edge, then compare.
    task automatic cycle(input string tag);
        int nv, nc, np, s;
        nv = m_valid; nc = m_code; np = m_ptr;
        if (m_valid != 0 && !out_ready) begin
            // held
        end else if (enable) begin
`ifdef PRIO_ENC_PIPE_RR_EN
            s = rr_pick(req, m_ptr);
`else
            s = fixed_pick(req);
`endif
            if (s >= 0) begin
                nv = 1; nc = s; np = s;
            end else begin
                nv = 0; nc = 0;
            end
        end else begin
            nv = 0; nc = 0;
        end
        @(posedge clock);
        #1;
        m_valid = nv; m_code = nc; m_ptr = np;
        compare_all(tag);
    endtask

    // Short asynchronous reset pulse between clock edges.
    task automatic reset_pulse();
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.valid", 32'(out_valid), 32'd0);
        chk("async_rst.onehot", 32'(out_onehot), 32'd0);
        compare_all("async_rst");
        #3 reset_n = 1'b1;
    endtask

`ifdef PRIO_ENC_PIPE_RR_EN
    int rr_seq[6] = '{0, 1, 15, 0, 1, 15};
`endif

    initial begin
        reset_n = 1'b0; enable = 1'b0; out_ready = 1'b0; req = '0;
        model_reset();
        #2;
        compare_all("reset");
        #10 reset_n = 1'b1;

        // Idle traffic never produces a grant
        enable = 1'b1; out_ready = 1'b1; req = '0;
        repeat (4) begin
            cycle("idle");
            chk("idle.lit_valid", 32'(out_valid), 32'd0);
            chk("idle.lit_onehot", 32'(out_onehot), 32'd0);
        end

`ifdef PRIO_ENC_PIPE_RR_EN
        req = 16'h8003;
        for (int i = 0; i < 6; i++) begin
            cycle("rr_seq");
            chk("rr_seq.lit_code", 32'(out_code), 32'(rr_seq[i]));
        end
        req = 16'h0020;
        repeat (4) begin
            cycle("rr_sole");
            chk("rr_sole.lit_code", 32'(out_code), 32'd5);
            chk("rr_sole.lit_valid", 32'(out_valid), 32'd1);
        end
        req = '0;
        cycle("rr_drop");
        chk("rr_drop.lit_valid", 32'(out_valid), 32'd0);
        req = 16'h0020;
        cycle("rr_pre_stall");
        out_ready = 1'b0;
        cycle("rr_stall");
        reset_pulse();
        req = 16'hFFFF; out_ready = 1'b1;
        cycle("rr_after_rst");
        chk("rr_after_rst.lit_code", 32'(out_code), 32'd0);
`else
        req = 16'h0A12;
        cycle("fixed");
        chk("fixed.lit_code", 32'(out_code), 32'd11);
        chk("fixed.lit_onehot", 32'(out_onehot), 32'h0800);
        chk("fixed.lit_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0; req = 16'h0001;
        repeat (3) begin
            cycle("stall");
            chk("stall.lit_code", 32'(out_code), 32'd11);
            chk("stall.lit_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        cycle("unstall");
        chk("unstall.lit_code", 32'(out_code), 32'd0);
        chk("unstall.lit_onehot", 32'(out_onehot), 32'h0001);
        out_ready = 1'b0;
        cycle("pre_rst_stall");
        reset_pulse();
        req = 16'hFFFF; out_ready = 1'b1;
        cycle("fixed_after_rst");
        chk("fixed_after_rst.lit_code", 32'(out_code), 32'd15);
`endif

        // Disabled with ready drains the output
        enable = 1'b0;
        cycle("drain");
        chk("drain.lit_valid", 32'(out_valid), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       req = '0;
                1:       req = IN'(1) << $urandom_range(0, IN - 1);
                2:       req = IN'($urandom);
                default: req = IN'($urandom) & IN'($urandom) & IN'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) reset_pulse();
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_enc_pipe.md
PRIO_ENC_PIPE -- requirements
Module: prio_enc_pipe

Interface
REQ-001 Parameter OUT_SIZE, default 4: code width in bits; legal range 1..8.
REQ-002 Parameter IN_SIZE, default 1<<OUT_SIZE: number of request lines; fixed at 1<<OUT_SIZE.
REQ-003 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port enable, input, 1: high permits sampling of req.
REQ-006 Port req, input, IN_SIZE: request vector; bit i set means requester i is active.
REQ-007 Port out_ready, input, 1: downstream accepts the current output.
REQ-008 Port out_valid, output, 1: out_code and out_onehot hold a grant.
REQ-009 Port out_code, output, OUT_SIZE: binary index of the granted requester.
REQ-010 Port out_onehot, output, IN_SIZE: decoded grant, equal to 1<<out_code when out_valid is high, otherwise zero.

Function
REQ-011 The block shall use a single registered output stage, with a latency of 1 clock from req sampling to out_valid.
REQ-012 Load condition: enable && (!out_valid || out_ready); req is sampled only on a load.
REQ-013 On a load with req != 0, the block shall register the selected index and set out_valid=1.
REQ-014 On a load with req == 0, the block shall set out_valid=0, out_code=0 and out_onehot=0.
REQ-015 Stall: out_valid && !out_ready shall hold out_code, out_onehot and out_valid unchanged, regardless of req or enable.
REQ-016 When enable=0 and out_ready=1 with out_valid=1, the block shall clear out_valid on the next edge; when enable=0 and out_valid=0, outputs shall stay idle.
REQ-017 Fixed-priority selection (default mode): the highest set index of req wins.
REQ-018 Grant pointer ptr (OUT_SIZE bits): on each load producing out_valid=1, ptr shall load the granted index.
REQ-019 Consecutive grants without an idle cycle are allowed: with out_ready held at 1, the block shall sustain one grant per clock.
REQ-020 out_onehot and out_code shall never disagree; no X/Z shall be driven on any output after reset.

Reset
REQ-021 When reset_n=0, the block shall immediately force out_valid=0, out_code=0 and out_onehot=0, with ptr=IN_SIZE-1.
REQ-022 A reset asserted mid-stall shall discard the held grant; the first edge after reset_n deasserts shall behave as an idle load.

Configuration
REQ-023 Macro PRIO_ENC_PIPE_RR_EN shall select the arbitration mode at compile time.
REQ-024 With PRIO_ENC_PIPE_RR_EN undefined, the block shall use fixed priority per REQ-017; ptr is still maintained but unused.
REQ-025 With PRIO_ENC_PIPE_RR_EN defined, selection shall be round-robin: search ptr+1, ptr+2, ... modulo IN_SIZE, and grant the first set bit.
REQ-026 In round-robin mode, a sole requester equal to ptr shall be granted again; the wrap from IN_SIZE-1 to 0 shall be seamless.
REQ-027 The port list and latency shall be identical in both modes.

Verification
REQ-028 Reset, then req=16'h0000, enable=1, out_ready=1 -> out_valid=0 and out_onehot=0 on every cycle.
REQ-029 Fixed mode, req=16'h0A12, enable=1, out_ready=1 -> 1 clock later out_code=11, out_onehot=16'h0800, out_valid=1.
REQ-030 Stall test: grant code=11 with out_ready=0 for 3 clocks while req changes to 16'h0001 -> outputs hold 11 throughout; the first edge with out_ready=1 loads code=0.
REQ-031 RR mode after reset, req=16'h8003 held, out_ready=1 -> out_code sequence 0,1,15,0,1,15.
REQ-032 RR mode, req=16'h0020 only, held for 4 clocks -> out_code=5 on every clock; then req=0 -> out_valid=0 on the next clock.
REQ-033 Mid-stall reset: out_valid=1, out_ready=0, pulse reset_n low for half a cycle -> out_valid=0 immediately (asynchronously); in RR mode, ptr=15 afterwards, so req=16'hFFFF grants code 0 first.
